// File: rtl/branch_pkg.sv
// ---------------------------------------------------------------------------
// branch_pkg
// Shared definitions for the branch resolve unit:
//   - func3_e   : conditional-branch condition codes (RISC-V func3 field)
//   - ctr_e     : 2-bit saturating prediction counter encodings
//   - CTR_RESET : value every prediction counter takes on reset
//   - ctr_next  : saturating increment/decrement of one counter
// ---------------------------------------------------------------------------
package branch_pkg;

    typedef enum logic [2:0] {
        F3_BEQ  = 3'b000,
        F3_BNE  = 3'b001,
        F3_RSV2 = 3'b010,
        F3_RSV3 = 3'b011,
        F3_BLT  = 3'b100,
        F3_BGE  = 3'b101,
        F3_BLTU = 3'b110,
        F3_BGEU = 3'b111
    } func3_e;

    typedef enum logic [1:0] {
        CTR_STRONG_NT = 2'b00,
        CTR_WEAK_NT   = 2'b01,
        CTR_WEAK_T    = 2'b10,
        CTR_STRONG_T  = 2'b11
    } ctr_e;

    localparam logic [1:0] CTR_RESET = CTR_WEAK_NT;

    // Move one counter toward the observed outcome, sticking at either end.
    function automatic logic [1:0] ctr_next(input logic [1:0] cur, input logic taken);
        logic [1:0] nxt;
        nxt = cur;
        if (taken) begin
            if (cur != CTR_STRONG_T) nxt = cur + 2'd1;
        end else begin
            if (cur != CTR_STRONG_NT) nxt = cur - 2'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/branch_compare.sv
// ---------------------------------------------------------------------------
// branch_compare
// Purely combinational evaluation of a conditional-branch condition.
// Ports:
//   rs1, rs2 : XLEN-bit operands
//   func3    : condition code (see branch_pkg::func3_e)
//   taken    : condition holds (always 0 for the two reserved codes)
//   legal    : func3 names a real branch condition
// ---------------------------------------------------------------------------
module branch_compare
    import branch_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic [2:0]      func3,
    output logic            taken,
    output logic            legal
);

    // One comparator per relation; the case below just selects among them.
    logic is_eq;
    logic is_lt;
    logic is_ltu;

    assign is_eq  = (rs1 == rs2);
    assign is_lt  = ($signed(rs1) < $signed(rs2));
    assign is_ltu = (rs1 < rs2);

    always_comb begin
        taken = 1'b0;
        legal = 1'b1;
        case (func3_e'(func3))
            F3_BEQ:  taken = is_eq;
            F3_BNE:  taken = ~is_eq;
            F3_BLT:  taken = is_lt;
            F3_BGE:  taken = ~is_lt;
            F3_BLTU: taken = is_ltu;
            F3_BGEU: taken = ~is_ltu;
            default: begin
                taken = 1'b0;
                legal = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// ---------------------------------------------------------------------------
// branch_resolve_unit
// Resolves execute-stage branches/jumps, registers the outcome and redirect
// target one cycle later, trains a table of 2-bit saturating counters and
// offers a combinational taken prediction for the fetch PC.
// Ports:
//   clk, rstN          : clock, asynchronous active-low reset
//   fetchPc            : PC being fetched;  predictTaken: its prediction
//   exValid, exFlush   : execute-stage instruction present / killed
//   exIsBranch         : conditional branch; jumpTypeInstFlag: JAL/JALR
//   exPc, exTarget     : instruction PC and its taken target
//   rs1Data, rs2Data   : branch operands; func3: condition code
//   exPredTaken        : prediction made for this instruction at fetch
//   resValid, branchTaken, mispredict, redirectPc : registered result
//   branchCount, mispredictCount : saturating statistics
// ---------------------------------------------------------------------------
module branch_resolve_unit
    import branch_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int BHT_ENTRIES = 16,
    parameter int CNTW        = 16
) (
    input  logic            clk,
    input  logic            rstN,
    input  logic [XLEN-1:0] fetchPc,
    output logic            predictTaken,
    input  logic            exValid,
    input  logic            exFlush,
    input  logic            exIsBranch,
    input  logic            jumpTypeInstFlag,
    input  logic [XLEN-1:0] exPc,
    input  logic [XLEN-1:0] exTarget,
    input  logic [XLEN-1:0] rs1Data,
    input  logic [XLEN-1:0] rs2Data,
    input  logic [2:0]      func3,
    input  logic            exPredTaken,
    output logic            resValid,
    output logic            branchTaken,
    output logic            mispredict,
    output logic [XLEN-1:0] redirectPc,
    output logic [CNTW-1:0] branchCount,
    output logic [CNTW-1:0] mispredictCount
);

    localparam int IDXW = $clog2(BHT_ENTRIES);

    logic [1:0]      bht [BHT_ENTRIES];
    logic [IDXW-1:0] fetch_idx;
    logic [IDXW-1:0] ex_idx;
    logic            cond_taken;
    logic            cond_legal;
    logic            fire;
    logic            outcome;
    logic            mispredict_next;
    logic            bht_update;
    logic [XLEN-1:0] redirect_next;
    logic            unused_pc_bits;

    // Instructions are word aligned, so the table index skips pc[1:0].
    assign fetch_idx = fetchPc[IDXW+1:2];
    assign ex_idx    = exPc[IDXW+1:2];

    assign unused_pc_bits = ^{fetchPc[XLEN-1:IDXW+2], fetchPc[1:0]};

    // Reads the stored counter directly: a same-cycle update to the same
    // entry is not forwarded, fetch sees the pre-update value.
    assign predictTaken = bht[fetch_idx][1];

    branch_compare #(.XLEN(XLEN)) u_compare (
        .rs1   (rs1Data),
        .rs2   (rs2Data),
        .func3 (func3),
        .taken (cond_taken),
        .legal (cond_legal)
    );

    // A jump wins over the branch flag, so it is always taken and never
    // trains the table.  Since jumps are always taken, a jump predicted
    // not-taken is already covered by the outcome/prediction comparison.
    always_comb begin
        fire            = exValid & ~exFlush & (exIsBranch | jumpTypeInstFlag);
        outcome         = jumpTypeInstFlag | cond_taken;
        mispredict_next = fire & (outcome != exPredTaken);
        bht_update      = fire & exIsBranch & ~jumpTypeInstFlag & cond_legal;
        redirect_next   = '0;
        if (fire) redirect_next = outcome ? exTarget : (exPc + XLEN'(4));
    end

    // Result register: everything except resValid is zeroed on idle cycles
    // so consumers never see a stale redirect.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            resValid    <= 1'b0;
            branchTaken <= 1'b0;
            mispredict  <= 1'b0;
            redirectPc  <= '0;
        end else begin
            resValid    <= fire;
            branchTaken <= fire & outcome;
            mispredict  <= mispredict_next;
            redirectPc  <= redirect_next;
        end
    end

    // Prediction table training.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            for (int i = 0; i < BHT_ENTRIES; i++) bht[i] <= CTR_RESET;
        end else if (bht_update) begin
            bht[ex_idx] <= ctr_next(bht[ex_idx], cond_taken);
        end
    end

    // Statistics counters stick at all-ones rather than wrapping.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            branchCount     <= '0;
            mispredictCount <= '0;
        end else begin
            if (fire && (branchCount != '1))
                branchCount <= branchCount + CNTW'(1);
            if (mispredict_next && (mispredictCount != '1))
                mispredictCount <= mispredictCount + CNTW'(1);
        end
    end

endmodule

// File: doc/branch_resolve_unit.md
BRANCH_RESOLVE_UNIT -- requirements
Module: branch_resolve_unit

Interface
REQ-001 SHALL have parameters: XLEN, default 32, datapath/PC width; BHT_ENTRIES, default 16, prediction-table depth, power of two, minimum 2; CNTW, default 16, statistics counter width.
REQ-002 SHALL have ports, clock and reset first:
- clk  in  1  sole clock; all state updates on its rising edge.
- rstN  in  1  asynchronous, active-low reset.
- fetchPc  in  XLEN  PC being fetched.
- predictTaken  out  1  combinational prediction for fetchPc.
- exValid  in  1  execute-stage instruction present.
- exFlush  in  1  kill the execute-stage instruction this cycle.
- exIsBranch  in  1  conditional branch.
- jumpTypeInstFlag  in  1  JAL/JALR, always taken.
- exPc  in  XLEN  PC of the execute-stage instruction.
- exTarget  in  XLEN  computed taken target.
- rs1Data, rs2Data  in  XLEN  operands.
- func3  in  3  branch condition.
- exPredTaken  in  1  prediction carried from fetch.
- resValid  out  1  registered result valid.
- branchTaken  out  1  registered actual outcome.
- mispredict  out  1  registered redirect request.
- redirectPc  out  XLEN  registered correct next PC.
- branchCount, mispredictCount  out  CNTW  statistics.

Function
REQ-003 SHALL let fire = exValid & ~exFlush & (exIsBranch | jumpTypeInstFlag); jumpTypeInstFlag takes priority if both type flags are set.
REQ-004 SHALL evaluate the condition on func3: 000 eq; 001 ne; 100 signed lt; 101 signed ge; 110 unsigned lt; 111 unsigned ge; 010/011 not taken. Jumps are always taken.
REQ-005 SHALL register the result with exactly one cycle latency: resValid=fire; branchTaken=outcome; redirectPc=outcome ? exTarget : exPc+4, computed mod 2^XLEN.
REQ-006 SHALL assert mispredict for one cycle when fire and (outcome != exPredTaken, or (outcome & jumpTypeInstFlag & ~exPredTaken)); otherwise 0.
REQ-007 SHALL hold the BHT as BHT_ENTRIES 2-bit saturating counters indexed by pc[log2(BHT_ENTRIES)+1:2]. Encodings: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
REQ-008 SHALL compute predictTaken = counter[fetchPc index][1], combinational.
REQ-009 SHALL update the BHT only when fire & exIsBranch & ~jumpTypeInstFlag & func3 is legal: increment on taken, decrement on not taken, saturating at 11 and 00.
REQ-010 SHALL, when the same index is read and updated in the same cycle, return the pre-update value on predictTaken (no bypass).
REQ-011 SHALL increment branchCount on each fire and mispredictCount on each mispredict, both saturating at 2^CNTW-1.
REQ-012 SHALL have exFlush suppress resValid, mispredict, the BHT update and the counter increments for that cycle.
REQ-013 SHALL hold mispredict and redirectPc at 0 whenever resValid=0.

Reset
REQ-014 SHALL, while rstN=0, asynchronously force resValid, branchTaken, mispredict, redirectPc, branchCount and mispredictCount to 0 and every BHT entry to 01.
REQ-015 SHALL, on reset assertion mid-operation, discard any pending result; the first post-reset resValid comes from the first fire sampled after rstN deasserts.

Structure
REQ-016 SHALL take func3 codes, counter encodings and the reset counter value from the shared package branch_pkg.
REQ-017 SHALL place the REQ-004 condition logic in one combinational sub-module, branch_compare; all state stays in branch_resolve_unit.

Verification
REQ-018 Verification SHALL cover:
- BEQ, rs1=rs2=5, exPredTaken=0, exTarget=0x100 -> next cycle resValid=1, branchTaken=1, mispredict=1, redirectPc=0x100.
- BLT rs1=0xFFFFFFFF, rs2=1 -> taken; BLTU with the same operands -> not taken, redirectPc=exPc+4.
- Three taken branches at exPc=0x40 from reset -> counter 01→10→11→11; predictTaken for fetchPc=0x40 reads 1 after the first update.
- exFlush=1 with a mispredicting branch -> resValid=0, mispredict=0, BHT and counters unchanged.
- JAL with exPredTaken=0 -> mispredict=1; BHT unchanged; func3=010 branch -> not taken, no BHT update.
- rstN pulsed low mid-stream -> all outputs 0 immediately and BHT entries 01; counters saturate at 0xFFFF with CNTW=16.
